// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
package reg_scoreboard_pkg;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int TW   = 2;
   localparam int CW   = 2;

   localparam logic [TW-1:0] TUSE_NOW  = 2'd0;
   localparam logic [TW-1:0] TNEW_NONE = 2'd0;
   localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
   localparam logic [TW-1:0] TNEW_LOAD = 2'd2;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rd;
      logic [TW-1:0] tnew;
   } issue_req_t;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
   } commit_req_t;
endpackage

// File: rtl/reg_score_entry.sv
// Pending-write count and youngest-producer latency for one register.
module reg_score_entry
   import reg_scoreboard_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   input  logic          load_tnew,
   input  logic [TW-1:0] tnew_in,
   output logic          busy,
   output logic [TW-1:0] tnew,
   output logic [CW-1:0] pend
);
   logic [CW-1:0] pend_d, pend_q;
   logic [TW-1:0] tnew_d, tnew_q;

   always_comb begin
      pend_d = pend_q;
      // Simultaneous issue and commit cancel out; underflow is flagged at the top.
      if (inc && !dec)
         pend_d = pend_q + 1'b1;
      else if (dec && !inc && pend_q != '0)
         pend_d = pend_q - 1'b1;

      tnew_d = tnew_q;
      if (load_tnew)
         tnew_d = tnew_in;
      else if (tnew_q != '0)
         tnew_d = tnew_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         tnew_q <= '0;
      end else begin
         pend_q <= pend_d;
         tnew_q <= tnew_d;
      end
   end

   assign busy = (pend_q != '0);
   assign tnew = tnew_q;
   assign pend = pend_q;
endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard tracker: per-register pending writes and forwarding latency.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [TW-1:0]   issue_tnew,
   input  logic [AW-1:0]   RA,
   input  logic [AW-1:0]   RB,
   input  logic [TW-1:0]   tuse_a,
   input  logic [TW-1:0]   tuse_b,
   input  logic            RegWrite,
   input  logic [AW-1:0]   Waddr,
   output logic            stall,
   output logic            issue_full,
   output logic [NREG-1:0] busy,
   output logic            err
);
   issue_req_t  iss;
   commit_req_t cmt;
   logic        issue_ok;
   logic        err_d, err_q;
   logic        haz_a, haz_b;

   logic [NREG-1:0][CW-1:0] pend_all;
   logic [NREG-1:0][TW-1:0] tnew_all;

   assign iss = '{valid: issue_valid && issue_rd != '0, rd: issue_rd, tnew: issue_tnew};
   assign cmt = '{valid: RegWrite && Waddr != '0, addr: Waddr};

   assign issue_full = iss.valid && (pend_all[iss.rd] == {CW{1'b1}});
   assign issue_ok   = iss.valid && !issue_full;

   // Register 0 carries no state and never reports busy.
   assign pend_all[0] = '0;
   assign tnew_all[0] = '0;
   assign busy[0]     = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_ent
      reg_score_entry u_ent (
         .clk       (clk),
         .reset     (reset),
         .inc       (issue_ok && iss.rd == AW'(g)),
         .dec       (cmt.valid && cmt.addr == AW'(g)),
         .load_tnew (issue_ok && iss.rd == AW'(g)),
         .tnew_in   (iss.tnew),
         .busy      (busy[g]),
         .tnew      (tnew_all[g]),
         .pend      (pend_all[g])
      );
   end

   // Equal tnew/tuse is covered by forwarding, so only strictly-later results stall.
   assign haz_a = (RA != '0) && (pend_all[RA] != '0) && (tnew_all[RA] > tuse_a);
   assign haz_b = (RB != '0) && (pend_all[RB] != '0) && (tnew_all[RB] > tuse_b);
   assign stall = haz_a || haz_b;

   always_comb begin
      err_d = err_q;
      if (cmt.valid && pend_all[cmt.addr] == '0)
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized scoreboard bench for reg_scoreboard against a per-register array model.
module tb_reg_scoreboard;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [1:0]  issue_tnew = '0;
   logic [4:0]  RA = '0, RB = '0;
   logic [1:0]  tuse_a = '0, tuse_b = '0;
   logic        RegWrite = 1'b0;
   logic [4:0]  Waddr = '0;
   logic        stall, issue_full, err;
   logic [31:0] busy;

   reg_scoreboard dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_tnew(issue_tnew), .RA(RA), .RB(RB), .tuse_a(tuse_a), .tuse_b(tuse_b),
      .RegWrite(RegWrite), .Waddr(Waddr), .stall(stall), .issue_full(issue_full),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        stall;
      bit        full;
      bit [31:0] busy;
      bit        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference state: in-flight write count and remaining latency per register.
   int   pend_m[32];
   int   tnew_m[32];
   bit   err_m = 0;
   bit   known = 0;

   function automatic bit hazard(input int r, input int tuse);
      return (r != 0) && (pend_m[r] > 0) && (tnew_m[r] > tuse);
   endfunction

   task automatic cyc(input bit iv, input int rd, input int tn, input int ra, input int ta,
                      input int rb, input int tb, input bit rw, input int wa, input bit rst);
      exp_t e;
      bit   full, ok, cm;
      @(negedge clk);
      #1;
      issue_valid = iv; issue_rd = rd[4:0]; issue_tnew = tn[1:0];
      RA = ra[4:0]; tuse_a = ta[1:0]; RB = rb[4:0]; tuse_b = tb[1:0];
      RegWrite = rw; Waddr = wa[4:0]; reset = rst;

      full = iv && rd != 0 && pend_m[rd] == 3;
      if (known) begin
         e.stall = hazard(ra, ta) || hazard(rb, tb);
         e.full  = full;
         e.err   = err_m;
         for (int r = 0; r < 32; r++) e.busy[r] = (r != 0) && pend_m[r] > 0;
         exp_q.push_back(e);
      end

      if (rst) begin
         for (int r = 0; r < 32; r++) begin pend_m[r] = 0; tnew_m[r] = 0; end
         err_m = 0;
         known = 1;
      end else begin
         ok = iv && rd != 0 && !full;
         cm = rw && wa != 0;
         if (cm && pend_m[wa] == 0) err_m = 1;
         for (int r = 1; r < 32; r++) if (tnew_m[r] > 0) tnew_m[r]--;
         if (ok) tnew_m[rd] = tn;
         if (!(ok && cm && rd == wa)) begin
            if (ok) pend_m[rd]++;
            if (cm && pend_m[wa] > 0) pend_m[wa]--;
         end
      end
   endtask

   task automatic idle(input int ra = 0, input int ta = 0);
      cyc(0, 0, 0, ra, ta, 0, 0, 0, 0, 0);
   endtask

   // Monitor: outputs are combinational or registered, so every cycle presents a response.
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (stall !== e.stall || issue_full !== e.full || busy !== e.busy || err !== e.err) begin
            n_bad++;
            $display("FAIL vec%0d: got stall=%b full=%b busy=%h err=%b, want stall=%b full=%b busy=%h err=%b",
                     n_vec, stall, issue_full, busy, err, e.stall, e.full, e.busy, e.err);
         end
      end
   end

   initial begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (4) idle();

      // Load-latency producer on r8 consumed immediately.
      cyc(1, 8, 2, 0, 0, 0, 0, 0, 0, 0);
      idle(8, 0); idle(8, 0); idle(8, 0);
      cyc(0, 0, 0, 8, 0, 0, 0, 1, 8, 0);
      idle(8, 0);

      // Equal tnew/tuse forwards; earlier use stalls.
      cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(5, 1);
      cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(5, 0);

      // Saturate r3, attempt a fourth issue, then drain.
      repeat (3) cyc(1, 3, 3, 0, 0, 3, 0, 0, 0, 0);
      cyc(1, 3, 1, 0, 0, 3, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 3, 0, 1, 3, 0);
      idle();

      // Same-cycle issue and commit on r9, then underflow on r4.
      cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 9, 3, 0, 0, 0, 0, 1, 9, 0);
      cyc(0, 0, 0, 9, 2, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
      idle(); idle();

      // Register 0 is inert; reset clears pending state and err.
      cyc(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 7, 3, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 7, 3, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 7, 0, 7, 1, 0, 0, 1);
      idle(7, 0); idle();

      // Random traffic on a small register window to provoke hazards and saturation.
      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(99) < 45, $urandom_range(7), $urandom_range(3),
             $urandom_range(7), $urandom_range(3), $urandom_range(7), $urandom_range(3),
             $urandom_range(99) < 35, $urandom_range(7), $urandom_range(99) < 2);
      end
      idle();

      repeat (3) @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d responses left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
